// File: rtl/dct_2d_sched.sv
// Scheduler for a 2-D NxN DCT: tracks row acceptance into a ping-pong pair of
// transpose banks, drives bank writes, and sequences N-cycle column read bursts.
module dct_2d_sched #(
  parameter int N       = 16,
  parameter int ROW_LAT = 4,
  parameter int COL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_bank,
  output logic [1:0]           wr_en,
  output logic [1:0]           rd_en,
  output logic                 rd_sel,
  output logic                 col_first,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 block_done,
  output logic                 busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, READ} rd_state_e;

  // Acceptance side: where the next row lands and which banks are spoken for.
  logic          acc_bank_q, acc_bank_d;
  logic [CW-1:0] acc_cnt_q,  acc_cnt_d;
  logic [1:0]    resv_q,     resv_d;

  // Write side: row-DCT pipeline tracking and per-bank fill state.
  logic [ROW_LAT-1:0] row_v_q, row_b_q;
  logic [CW-1:0]      wr_cnt_q [2];
  logic [CW-1:0]      wr_cnt_d [2];
  logic [1:0]         done_q, done_d;

  // Read side.
  rd_state_e     state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_cnt_q,  rd_cnt_d;

  // Column-DCT output tracking.
  logic [COL_LAT-1:0]         col_v_q;
  logic [COL_LAT-1:0][CW-1:0] col_idx_q;

  logic accept, acc_last, wr_fire, wr_tag, wr_last, rd_last;

  // NOTE: in_ready is gated by rstn so the handshake is closed while reset is
  // held, even though resv_q already reads as "both banks free".
  assign in_ready = rstn && !resv_q[acc_bank_q];
  assign accept   = in_valid && in_ready;
  assign acc_last = accept && (acc_cnt_q == LAST);

  assign wr_fire = row_v_q[ROW_LAT-1];
  assign wr_tag  = row_b_q[ROW_LAT-1];
  assign wr_last = wr_fire && (wr_cnt_q[wr_tag] == LAST);
  assign rd_last = (state_q == READ) && (rd_cnt_q == LAST);

  assign wr_en   = wr_fire ? (wr_tag ? 2'b10 : 2'b01) : 2'b00;
  assign wr_bank = wr_fire && wr_tag;

  // NOTE: every variable written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_bank_d = acc_bank_q;
    resv_d     = resv_q;
    done_d     = done_q;
    wr_cnt_d   = wr_cnt_q;

    if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
      if (acc_last) begin
        acc_cnt_d          = '0;
        acc_bank_d         = ~acc_bank_q;
        resv_d[acc_bank_q] = 1'b1;
      end
    end

    if (wr_fire) begin
      wr_cnt_d[wr_tag] = wr_last ? '0 : wr_cnt_q[wr_tag] + 1'b1;
      if (wr_last) done_d[wr_tag] = 1'b1;
    end

    // A bank being freed is never the bank being reserved or filled this cycle.
    if (rd_last) begin
      resv_d[rd_bank_q] = 1'b0;
      done_d[rd_bank_q] = 1'b0;
    end
  end

  // Read FSM looks at done_d so a bank finishing its last write this cycle
  // starts its burst on the very next cycle, and bursts can run back-to-back.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_en     = 2'b00;
    rd_sel    = 1'b0;
    col_first = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (done_d[rd_bank_q]) state_d = READ;
      end
      READ: begin
        rd_en[rd_bank_q] = 1'b1;
        rd_sel           = rd_bank_q;
        col_first        = (rd_cnt_q == '0);
        if (rd_last) begin
          rd_cnt_d  = '0;
          rd_bank_d = ~rd_bank_q;
          state_d   = done_d[~rd_bank_q] ? READ : IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_bank_q <= 1'b0;
      acc_cnt_q  <= '0;
      resv_q     <= 2'b00;
      row_v_q    <= '0;
      row_b_q    <= '0;
      wr_cnt_q   <= '{default: '0};
      done_q     <= 2'b00;
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      col_v_q    <= '0;
      col_idx_q  <= '0;
    end else begin
      acc_bank_q <= acc_bank_d;
      acc_cnt_q  <= acc_cnt_d;
      resv_q     <= resv_d;
      row_v_q    <= {row_v_q[ROW_LAT-2:0], accept};
      row_b_q    <= {row_b_q[ROW_LAT-2:0], acc_bank_q};
      wr_cnt_q   <= wr_cnt_d;
      done_q     <= done_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      col_v_q    <= {col_v_q[COL_LAT-2:0], |rd_en};
      col_idx_q  <= {col_idx_q[COL_LAT-2:0], rd_cnt_q};
    end
  end

  // rd_cnt_q rests at zero outside bursts, so out_idx is zero whenever idle.
  assign out_valid  = col_v_q[COL_LAT-1];
  assign out_idx    = col_idx_q[COL_LAT-1];
  assign block_done = out_valid && (out_idx == LAST);

  assign busy = (|row_v_q) || (|col_v_q) || (state_q == READ) ||
                (|resv_q) || (acc_cnt_q != '0);

endmodule

// File: tb/tb_dct_2d_sched.sv
// Directed bench for dct_2d_sched: per-cycle output snapshots compared against
// hand-computed tables, plus sequence checks for streaming, gaps and reset.
module tb_dct_2d_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_bank, rd_sel, col_first, out_valid, block_done, busy;
  logic [1:0] wr_en, rd_en;
  logic [3:0] out_idx;

  dct_2d_sched #(.N(16), .ROW_LAT(4), .COL_LAT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_bank    (wr_bank),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .col_first  (col_first),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .block_done (block_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir;
    logic [1:0] wr;
    logic       wb;
    logic [1:0] rd;
    logic       rs;
    logic       cf;
    logic       ov;
    logic [3:0] idx;
    logic       bd;
    logic       bu;
  } snap_t;

  typedef struct {
    int    test;
    int    cyc;
    snap_t exp;
  } vec_t;

  localparam int MAXC = 256;

  vec_t  vecs[$];
  snap_t tr [MAXC];
  int    cyc, accepted, checks, errors;

  function automatic snap_t cur();
    snap_t s;
    s.ir = in_ready;  s.wr = wr_en;     s.wb = wr_bank;  s.rd = rd_en;
    s.rs = rd_sel;    s.cf = col_first; s.ov = out_valid; s.idx = out_idx;
    s.bd = block_done; s.bu = busy;
    return s;
  endfunction

  function automatic snap_t mk(int ir, int wr, int wb, int rd, int rs, int cf,
                               int ov, int idx, int bd, int bu);
    snap_t s;
    s.ir = 1'(ir); s.wr = 2'(wr); s.wb = 1'(wb); s.rd = 2'(rd); s.rs = 1'(rs);
    s.cf = 1'(cf); s.ov = 1'(ov); s.idx = 4'(idx); s.bd = 1'(bd); s.bu = 1'(bu);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int t, input int c, input snap_t e);
    vec_t v;
    v.test = t; v.cyc = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    accepted = 0;
  endtask

  // One cycle: drive in_valid, sample everything mid-cycle, advance past the edge.
  task automatic step(input logic v);
    in_valid = v;
    @(negedge clk);
    if (cyc < MAXC) tr[cyc] = cur();
    if (v && in_ready) accepted++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_table(input int t, input string tag);
    foreach (vecs[i]) begin
      if (vecs[i].test == t)
        check($sformatf("%s_c%0d", tag, vecs[i].cyc), 32'(tr[vecs[i].cyc]), 32'(vecs[i].exp));
    end
  endtask

  task automatic run_single(input string tag);
    for (int i = 0; i < 46; i++) step(i < 16);
    check_table(1, tag);
  endtask

  int n_wr0, n_wr1, n_rd, n_ov, n_bd, n_cf, n_lo, n_bad, run, max_run, exp_idx;
  logic [7:0] rs_seq;

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    checks = 0;
    errors = 0;

    // Test 1: single block, 16 accepts in cycles 0..15.
    //        ir wr wb rd rs cf ov idx bd bu
    add(1,  0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1,  1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1,  3, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1,  4, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 19, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(1, 20, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    add(1, 21, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    add(1, 24, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    add(1, 35, mk(1, 0, 0, 1, 0, 0, 1, 11, 0, 1));
    add(1, 36, mk(1, 0, 0, 0, 0, 0, 1, 12, 0, 1));
    add(1, 39, mk(1, 0, 0, 0, 0, 0, 1, 15, 1, 1));
    add(1, 40, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Test 2: in_valid held until 48 rows accepted; stalls 32..35 with both banks full.
    add(2, 20, mk(1, 2, 1, 1, 0, 1, 0, 0, 0, 1));
    add(2, 31, mk(1, 2, 1, 1, 0, 0, 1, 7, 0, 1));
    add(2, 32, mk(0, 2, 1, 1, 0, 0, 1, 8, 0, 1));
    add(2, 35, mk(0, 2, 1, 1, 0, 0, 1, 11, 0, 1));
    add(2, 36, mk(1, 0, 0, 2, 1, 1, 1, 12, 0, 1));
    add(2, 39, mk(1, 0, 0, 2, 1, 0, 1, 15, 1, 1));
    add(2, 40, mk(1, 1, 0, 2, 1, 0, 1, 0, 0, 1));
    add(2, 51, mk(1, 1, 0, 2, 1, 0, 1, 11, 0, 1));
    add(2, 52, mk(1, 1, 0, 0, 0, 0, 1, 12, 0, 1));
    add(2, 55, mk(1, 1, 0, 0, 0, 0, 1, 15, 1, 1));
    add(2, 56, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    add(2, 71, mk(1, 0, 0, 1, 0, 0, 1, 11, 0, 1));
    add(2, 75, mk(1, 0, 0, 0, 0, 0, 1, 15, 1, 1));
    add(2, 76, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Test 3: one row every other cycle (cycles 0,2,..,30).
    add(3,  4, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(3,  5, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(3, 33, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(3, 34, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    add(3, 35, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    add(3, 50, mk(1, 0, 0, 1, 0, 0, 1, 11, 0, 1));
    add(3, 51, mk(1, 0, 0, 0, 0, 0, 1, 12, 0, 1));
    add(3, 54, mk(1, 0, 0, 0, 0, 0, 1, 15, 1, 1));
    add(3, 55, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ---- Test 1: single block ----
    do_reset();
    check("reset_release", 32'(cur()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    run_single("single");
    n_wr0 = 0;
    for (int c = 0; c < 46; c++) if (tr[c].wr == 2'b01) n_wr0++;
    check("single_wr0_count", 32'(n_wr0), 32'd16);

    // ---- Test 2: streaming with full-stall ----
    do_reset();
    for (int i = 0; i < 86; i++) step(accepted < 48);
    check_table(2, "stream");
    check("stream_accepted", 32'(accepted), 32'd48);
    n_bd = 0; n_ov = 0; n_cf = 0; n_lo = 0; n_bad = 0; exp_idx = 0; rs_seq = '0;
    n_wr0 = 0; n_wr1 = 0;
    for (int c = 0; c < 86; c++) begin
      if (tr[c].bd) n_bd++;
      if (!tr[c].ir) n_lo++;
      if (tr[c].wr == 2'b01) n_wr0++;
      if (tr[c].wr == 2'b10) n_wr1++;
      if (tr[c].cf) begin
        rs_seq = {rs_seq[6:0], tr[c].rs};
        n_cf++;
      end
      if (tr[c].ov) begin
        if (tr[c].idx != 4'(exp_idx)) n_bad++;
        exp_idx = (exp_idx + 1) % 16;
        n_ov++;
      end
    end
    check("stream_block_done", 32'(n_bd), 32'd3);
    check("stream_out_words", 32'(n_ov), 32'd48);
    check("stream_idx_order_errs", 32'(n_bad), 32'd0);
    check("stream_ready_low", 32'(n_lo), 32'd4);
    check("stream_bursts", 32'(n_cf), 32'd3);
    check("stream_rd_sel_order", 32'(rs_seq[2:0]), 32'b010);
    check("stream_wr0_count", 32'(n_wr0), 32'd32);
    check("stream_wr1_count", 32'(n_wr1), 32'd16);

    // ---- Test 3: gapped input ----
    do_reset();
    for (int i = 0; i < 60; i++) step((i < 32) && (i % 2 == 0));
    check_table(3, "gap");
    n_wr0 = 0; n_rd = 0; run = 0; max_run = 0;
    for (int c = 0; c < 60; c++) begin
      if (tr[c].wr == 2'b01) n_wr0++;
      if (tr[c].rd == 2'b01) begin
        n_rd++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("gap_wr_count", 32'(n_wr0), 32'd16);
    check("gap_rd_count", 32'(n_rd), 32'd16);
    check("gap_rd_contiguous", 32'(max_run), 32'd16);

    // ---- Test 4: reset during the 8th write of bank 1 while bank 0 is read ----
    do_reset();
    for (int i = 0; i < 27; i++) step(1'b1);
    in_valid = 1'b1;
    check("midrst_pre_wr", 32'(wr_en), 32'b10);
    check("midrst_pre_rd", 32'(rd_en), 32'b01);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_async", 32'(cur()), 32'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_held", 32'(cur()), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    accepted = 0;
    for (int i = 0; i < 25; i++) step(1'b0);
    n_ov = 0; n_lo = 0; n_bd = 0;
    for (int c = 0; c < 25; c++) begin
      if (tr[c].ov || tr[c].rd != 2'b00 || tr[c].wr != 2'b00) n_ov++;
      if (!tr[c].ir) n_lo++;
      if (tr[c].bu) n_bd++;
    end
    check("midrst_no_activity", 32'(n_ov), 32'd0);
    check("midrst_ready_high", 32'(n_lo), 32'd0);
    check("midrst_not_busy", 32'(n_bd), 32'd0);
    cyc = 0;
    run_single("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
